// File: rtl/mem_port_sequencer.sv
// Memory-port sequencer: arbitrates fetch (IF) and load/store (D) requests onto one shared memory bus.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_port_sequencer #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [WORD_SIZE-1:0]  if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_done,
    output logic [WORD_SIZE-1:0]  d_rdata,
    output logic                  readM,
    output logic                  writeM,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [WORD_SIZE-1:0]  data,
    input  logic                  inputReady,
    input  logic                  ackOutput,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_next;
    logic [WORD_SIZE-1:0]  if_rdata_next, d_rdata_next;
    logic                  readM_next, writeM_next, if_ready_next, d_done_next;
    logic                  timed_out;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tcnt;
    logic          err_next;

    // Zero on every access entry because the FSM always passes through IDLE first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (state == FETCH || state == READ || state == WRITE) begin
            tcnt <= tcnt + CW'(1);
        end else begin
            tcnt <= '0;
        end
    end

    assign timed_out = (tcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err <= 1'b0;
        else          err <= err_next;
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    // Bus data is driven only while the write strobe phase is active.
    assign data = (state == WRITE) ? wdata_q : {WORD_SIZE{1'bz}};
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            address  <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            readM    <= 1'b0;
            writeM   <= 1'b0;
            if_ready <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            state    <= state_next;
            address  <= address_next;
            wdata_q  <= wdata_next;
            if_rdata <= if_rdata_next;
            d_rdata  <= d_rdata_next;
            readM    <= readM_next;
            writeM   <= writeM_next;
            if_ready <= if_ready_next;
            d_done   <= d_done_next;
        end
    end

    always_comb begin
        state_next    = state;
        address_next  = address;
        wdata_next    = wdata_q;
        if_rdata_next = if_rdata;
        d_rdata_next  = d_rdata;
        readM_next    = 1'b0;
        writeM_next   = 1'b0;
        if_ready_next = 1'b0;
        d_done_next   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        err_next      = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Data requests win; a pending fetch waits for the next IDLE.
                if (d_req) begin
                    address_next = d_addr;
                    wdata_next   = d_wdata;
                    if (d_we) begin
                        writeM_next = 1'b1;
                        state_next  = WRITE;
                    end else begin
                        readM_next = 1'b1;
                        state_next = READ;
                    end
                end else if (if_req) begin
                    address_next = if_addr;
                    readM_next   = 1'b1;
                    state_next   = FETCH;
                end
            end
            FETCH, READ: begin
                if (inputReady || timed_out) begin
                    state_next = RELEASE;
                    if (state == FETCH) begin
                        if_rdata_next = inputReady ? data : {WORD_SIZE{1'b1}};
                        if_ready_next = 1'b1;
                    end else begin
                        d_rdata_next = inputReady ? data : {WORD_SIZE{1'b1}};
                        d_done_next  = 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    err_next = !inputReady;
`endif
                end else begin
                    readM_next = 1'b1;
                end
            end
            WRITE: begin
                if (ackOutput || timed_out) begin
                    state_next  = RELEASE;
                    d_done_next = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    err_next = !ackOutput;
`endif
                end else begin
                    writeM_next = 1'b1;
                end
            end
            RELEASE: begin
                if (!inputReady && !ackOutput) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: directed plan steps plus random fetch/load/store traffic against a memory reference model.
module tb_mem_port_sequencer;
    localparam int W  = 16;
    localparam int A  = 16;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         if_req, d_req, d_we;
    logic [A-1:0] if_addr, d_addr;
    logic [W-1:0] d_wdata;
    logic         if_ready, d_done, readM, writeM, busy, err;
    logic [W-1:0] if_rdata, d_rdata, mem_rdata;
    logic [A-1:0] address;
    logic         inputReady, ackOutput;
    tri1  [W-1:0] data;

    int checks = 0;
    int errors = 0;

    mem_port_sequencer #(.WORD_SIZE(W), .ADDR_WIDTH(A), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .readM(readM), .writeM(writeM), .address(address), .data(data),
        .inputReady(inputReady), .ackOutput(ackOutput), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    assign data = inputReady ? mem_rdata : {W{1'bz}};

    // Memory contents seen by the bus, and the bench's own view of what they should be.
    logic [W-1:0] mem     [logic [A-1:0]];
    logic [W-1:0] ref_mem [logic [A-1:0]];

    function automatic logic [W-1:0] init_word(input logic [A-1:0] a);
        return (a * 16'd7) ^ 16'h3C96;
    endfunction
    function automatic logic [W-1:0] mem_rd(input logic [A-1:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic logic [W-1:0] ref_rd(input logic [A-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    int           mem_lat  = 0;
    int           mem_hold = 0;
    int           mcnt     = 0;
    int           hcnt     = 0;
    logic [A-1:0] last_wr_addr = '0;
    logic [W-1:0] last_wr_data = '0;

    // Responds mem_lat cycles after a strobe; holds the response mem_hold extra cycles after the strobe drops.
    always @(negedge clk) begin
        if (!reset_n) begin
            inputReady = 1'b0; ackOutput = 1'b0; mcnt = 0; hcnt = 0;
        end else if (readM && !inputReady) begin
            if (mcnt >= mem_lat) begin
                mem_rdata  = mem_rd(address);
                inputReady = 1'b1;
            end else mcnt++;
        end else if (writeM && !ackOutput) begin
            if (mcnt >= mem_lat) begin
                mem[address] = data;
                last_wr_addr = address;
                last_wr_data = data;
                ackOutput    = 1'b1;
            end else mcnt++;
        end else if (!readM && !writeM) begin
            if ((inputReady || ackOutput) && hcnt < mem_hold) hcnt++;
            else begin
                inputReady = 1'b0; ackOutput = 1'b0; mcnt = 0; hcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // kind: 0 = fetch, 1 = load, 2 = store
    task automatic access(input int kind, input logic [A-1:0] a, input logic [W-1:0] wd,
                          input int lat, input int hold);
        logic [W-1:0] exp;
        int           strobes, rel;
        bit           got;
        mem_lat  = lat;
        mem_hold = hold;
        if (kind == 0) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            d_req = 1'b1; d_we = (kind == 2); d_addr = a; d_wdata = wd;
        end
        exp = (kind == 2) ? wd : ref_rd(a);
        if (kind == 2) ref_mem[a] = wd;
        strobes = 0;
        got     = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            step();
            got = (kind == 0) ? if_ready : d_done;
            if (!got && (readM || writeM)) begin
                strobes++;
                if (kind == 2 && strobes == 1) chk("wdata_on_bus", data, wd);
            end
        end
        chk("pulse_seen", got, 1);
        if (got) begin
            if (kind == 0)      chk("if_rdata", if_rdata, exp);
            else if (kind == 1) chk("d_rdata", d_rdata, exp);
            else begin
                chk("wr_addr", last_wr_addr, a);
                chk("wr_data", last_wr_data, wd);
                chk("data_released", data, 16'hFFFF);
            end
            chk("strobes_dropped", {readM, writeM}, 0);
            chk("err_low", err, 0);
            chk("strobe_cycles", strobes, lat + 1);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        rel    = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (n == 0) chk("single_pulse", {if_ready, d_done}, 0);
            if (!busy) break;
            rel++;
        end
        chk("release_cycles", rel, hold);
    endtask

    initial begin
        int           n;
        int           strobes;
        bit           got_d, got_i;
        reset_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        inputReady = 1'b0; ackOutput = 1'b0;

        // Reset state
        step(); step();
        chk("rst_strobes", {readM, writeM}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_z", data, 16'hFFFF);
        chk("rst_address", address, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_pulses", {if_ready, d_done, err}, 0);
        reset_n = 1'b1;
        step();

        // Fetch with a slow memory that also lingers in the release phase
        mem[16'h0004] = 16'h6A05; ref_mem[16'h0004] = 16'h6A05;
        access(0, 16'h0004, '0, 3, 1);
        chk("address_holds", address, 16'h0004);

        // Store
        access(2, 16'h0010, 16'hBEEF, 2, 0);
        access(1, 16'h0010, '0, 0, 0);

        // Priority: both requests in the same cycle, load goes first
        mem[16'h0020] = 16'h1234; ref_mem[16'h0020] = 16'h1234;
        mem_lat = 0; mem_hold = 0;
        if_req = 1'b1; if_addr = 16'h0004;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        got_d = 1'b0; got_i = 1'b0;
        for (n = 0; n < 50 && !got_d && !got_i; n++) begin
            step();
            got_d = d_done; got_i = if_ready;
        end
        chk("prio_d_first", {got_d, got_i}, 2'b10);
        chk("prio_d_rdata", d_rdata, 16'h1234);
        d_req = 1'b0;
        got_d = 1'b0; got_i = 1'b0;
        for (n = 0; n < 50 && !got_i; n++) begin
            step();
            got_i = if_ready;
            if (d_done) got_d = 1'b1;
        end
        chk("prio_if_served", got_i, 1);
        chk("prio_no_second_d", got_d, 0);
        chk("prio_if_rdata", if_rdata, ref_rd(16'h0004));
        if_req = 1'b0;
        for (n = 0; n < 20 && (busy || n == 0); n++) step();
        chk("prio_idle", busy, 0);

`ifdef MEM_TIMEOUT_EN
        // Load never answered
        mem_lat = 1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        strobes = 0; got_d = 1'b0;
        for (n = 0; n < 100 && !got_d; n++) begin
            step();
            got_d = d_done;
            if (!got_d && readM) strobes++;
        end
        chk("to_done", got_d, 1);
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 16'hFFFF);
        chk("to_readM", readM, 0);
        chk("to_cycles", strobes, TO);
        d_req = 1'b0;
        step();
        chk("to_err_pulse", err, 0);
        for (n = 0; n < 20 && busy; n++) step();
        chk("to_idle", busy, 0);
`endif

        // Reset in the middle of a store
        mem_lat = 1000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555;
        for (n = 0; n < 10 && !writeM; n++) step();
        chk("mid_writeM", writeM, 1);
        chk("mid_data", data, 16'h5555);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_writeM", writeM, 0);
        chk("mid_rst_data_z", data, 16'hFFFF);
        chk("mid_rst_busy", busy, 0);
        d_req = 1'b0;
        got_d = 1'b0;
        for (n = 0; n < 3; n++) begin
            step();
            if (d_done) got_d = 1'b1;
        end
        chk("mid_no_done", got_d, 0);
        reset_n = 1'b1;
        step();

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            access($urandom_range(0, 2), A'($urandom_range(0, 15)), W'($urandom),
                   $urandom_range(0, 4), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
